// File: rtl/lpif_tx_arbiter.sv
// lpif_tx_arbiter: arbitrates one link's LPIF transmit port between the DLL's
// DLLP requester and TLP requester.
//
// Behaviour:
//  - The output beat is held in a register stage. A new beat may be loaded
//    when the stage is empty or its current beat is being taken by the PHY.
//  - New packets start only while the link is up and in L0.
//  - Losing the link empties the stage. The remainder of an in-flight TLP is
//    then consumed and dropped until its last beat has gone by.
//
// Optional build macro LPIF_TX_ARB_PERF_EN adds three free-running 32-bit
// performance counters:
//  - completed TLPs,
//  - completed DLLPs,
//  - cycles stalled by the PHY.

module lpif_tx_arbiter #(
    parameter int unsigned DATA_W        = 512,
    parameter int unsigned DLP_BURST_MAX = 4,
    parameter logic [3:0]  L0_STATE      = 4'h1
) (
    input  logic                  LCLK,
    input  logic                  lpreset,
    input  logic                  pl_linkUp,
    input  logic [3:0]            pl_state_sts,
    input  logic                  pl_trdy,
    input  logic                  tlp_valid,
    input  logic [DATA_W-1:0]     tlp_data,
    input  logic [DATA_W/8-1:0]   tlp_bvalid,
    input  logic                  tlp_sop,
    input  logic                  tlp_eop,
    output logic                  tlp_ready,
    input  logic                  dlp_valid,
    input  logic [63:0]           dlp_data,
    output logic                  dlp_ready,
    output logic                  lp_irdy,
    output logic [DATA_W-1:0]     lp_data,
    output logic [DATA_W/8-1:0]   lp_valid,
    output logic [DATA_W/8-1:0]   lp_tlpstart,
    output logic [DATA_W/8-1:0]   lp_tlpend,
    output logic [DATA_W/8-1:0]   lp_dlpstart,
    output logic [DATA_W/8-1:0]   lp_dlpend,
`ifdef LPIF_TX_ARB_PERF_EN
    output logic [31:0]           perf_tlp_cnt,
    output logic [31:0]           perf_dlp_cnt,
    output logic [31:0]           perf_stall_cnt,
`endif
    output logic                  arb_busy
);

    localparam int unsigned NB = DATA_W / 8;

    // Lane 0 marker. Every other lane marker is this value shifted left.
    localparam logic [NB-1:0] LANE0     = {{(NB-1){1'b0}}, 1'b1};
    localparam logic [NB-1:0] LANE7     = LANE0 << 7;
    localparam logic [NB-1:0] DLP_LANES = {{(NB-8){1'b0}}, 8'hFF};
    localparam logic [3:0]    BURST_MAX = 4'(DLP_BURST_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TLP   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // One-hot marker on the highest valid lane. Lane valids are contiguous
    // from lane 0, so this is the last byte of the beat.
    function automatic logic [NB-1:0] last_lane(input logic [NB-1:0] bv);
        logic [NB-1:0] r;
        r = {NB{1'b0}};
        for (int i = 0; i < NB; i++) begin
            if (bv[i]) begin
                r = LANE0 << i;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              lp_irdy_q, lp_irdy_d;
    logic [DATA_W-1:0] lp_data_q, lp_data_d;
    logic [NB-1:0]     lp_valid_q, lp_valid_d;
    logic [NB-1:0]     lp_tlpstart_q, lp_tlpstart_d;
    logic [NB-1:0]     lp_tlpend_q, lp_tlpend_d;
    logic [NB-1:0]     lp_dlpstart_q, lp_dlpstart_d;
    logic [NB-1:0]     lp_dlpend_q, lp_dlpend_d;

    logic link_ok_s;
    logic load_s;
    logic dlp_win_s;
    logic grant_tlp_s;
    logic grant_dlp_s;
    logic drain_s;
    logic tlp_take_s;
    logic tlp_acc_s;
    logic dlp_acc_s;

    assign link_ok_s = pl_linkUp && (pl_state_sts == L0_STATE);
    assign load_s    = !lp_irdy_q || pl_trdy;

    // A DLLP wins unless a TLP has already waited through a full DLLP burst.
    assign dlp_win_s = dlp_valid && (!tlp_valid || (starve_q < BURST_MAX));

    // Decide which requester owns the output stage this cycle.
    always_comb begin
        grant_tlp_s = 1'b0;
        grant_dlp_s = 1'b0;
        drain_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dlp_win_s) begin
                    grant_dlp_s = 1'b1;
                end else if (tlp_valid && tlp_sop) begin
                    grant_tlp_s = 1'b1;
                end else begin
                    grant_tlp_s = 1'b0;
                end
            end
            ST_TLP:   grant_tlp_s = 1'b1;
            ST_DRAIN: drain_s     = 1'b1;
            default:  grant_tlp_s = 1'b0;
        endcase
    end

    // In DRAIN the rest of a broken TLP is consumed and dropped,
    // regardless of link state.
    assign tlp_ready  = drain_s || (load_s && grant_tlp_s && link_ok_s);
    assign dlp_ready  = load_s && grant_dlp_s && link_ok_s;
    assign tlp_take_s = tlp_valid && tlp_ready;
    assign tlp_acc_s  = tlp_take_s && !drain_s;
    assign dlp_acc_s  = dlp_valid && dlp_ready;

    // Next state: packets are never interleaved, and link loss mid-packet drains.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tlp_acc_s && !tlp_eop) begin
                    state_d = ST_TLP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TLP: begin
                if (!link_ok_s) begin
                    state_d = ST_DRAIN;
                end else if (tlp_acc_s && tlp_eop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_TLP;
                end
            end
            ST_DRAIN: begin
                if (tlp_take_s && tlp_eop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Starvation counter: counts DLLP grants taken while a TLP was waiting.
    always_comb begin
        starve_d = starve_q;
        if (dlp_acc_s) begin
            if (tlp_valid) begin
                if (starve_q != 4'hF) begin
                    starve_d = starve_q + 4'd1;
                end else begin
                    starve_d = starve_q;
                end
            end else begin
                starve_d = 4'd0;
            end
        end else if (tlp_acc_s && (state_q == ST_IDLE)) begin
            starve_d = 4'd0;
        end else begin
            starve_d = starve_q;
        end
    end

    // Output stage: load the granted beat, empty it, or hold it while the PHY stalls.
    always_comb begin
        lp_irdy_d     = lp_irdy_q;
        lp_data_d     = lp_data_q;
        lp_valid_d    = lp_valid_q;
        lp_tlpstart_d = lp_tlpstart_q;
        lp_tlpend_d   = lp_tlpend_q;
        lp_dlpstart_d = lp_dlpstart_q;
        lp_dlpend_d   = lp_dlpend_q;
        if (!link_ok_s || (load_s && !tlp_acc_s && !dlp_acc_s)) begin
            lp_irdy_d     = 1'b0;
            lp_data_d     = {DATA_W{1'b0}};
            lp_valid_d    = {NB{1'b0}};
            lp_tlpstart_d = {NB{1'b0}};
            lp_tlpend_d   = {NB{1'b0}};
            lp_dlpstart_d = {NB{1'b0}};
            lp_dlpend_d   = {NB{1'b0}};
        end else if (tlp_acc_s) begin
            lp_irdy_d     = 1'b1;
            lp_data_d     = tlp_data;
            lp_valid_d    = tlp_bvalid;
            lp_tlpstart_d = tlp_sop ? LANE0 : {NB{1'b0}};
            lp_tlpend_d   = tlp_eop ? last_lane(tlp_bvalid) : {NB{1'b0}};
            lp_dlpstart_d = {NB{1'b0}};
            lp_dlpend_d   = {NB{1'b0}};
        end else if (dlp_acc_s) begin
            lp_irdy_d     = 1'b1;
            lp_data_d     = {{(DATA_W-64){1'b0}}, dlp_data};
            lp_valid_d    = DLP_LANES;
            lp_tlpstart_d = {NB{1'b0}};
            lp_tlpend_d   = {NB{1'b0}};
            lp_dlpstart_d = LANE0;
            lp_dlpend_d   = LANE7;
        end else begin
            lp_irdy_d     = lp_irdy_q;
        end
    end

    // State, counter and output-stage registers.
    always_ff @(posedge LCLK) begin
        if (lpreset) begin
            state_q       <= ST_IDLE;
            starve_q      <= 4'd0;
            lp_irdy_q     <= 1'b0;
            lp_data_q     <= {DATA_W{1'b0}};
            lp_valid_q    <= {NB{1'b0}};
            lp_tlpstart_q <= {NB{1'b0}};
            lp_tlpend_q   <= {NB{1'b0}};
            lp_dlpstart_q <= {NB{1'b0}};
            lp_dlpend_q   <= {NB{1'b0}};
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            lp_irdy_q     <= lp_irdy_d;
            lp_data_q     <= lp_data_d;
            lp_valid_q    <= lp_valid_d;
            lp_tlpstart_q <= lp_tlpstart_d;
            lp_tlpend_q   <= lp_tlpend_d;
            lp_dlpstart_q <= lp_dlpstart_d;
            lp_dlpend_q   <= lp_dlpend_d;
        end
    end

    assign lp_irdy     = lp_irdy_q;
    assign lp_data     = lp_data_q;
    assign lp_valid    = lp_valid_q;
    assign lp_tlpstart = lp_tlpstart_q;
    assign lp_tlpend   = lp_tlpend_q;
    assign lp_dlpstart = lp_dlpstart_q;
    assign lp_dlpend   = lp_dlpend_q;
    assign arb_busy    = (state_q != ST_IDLE) || lp_irdy_q;

`ifdef LPIF_TX_ARB_PERF_EN
    logic [31:0] perf_tlp_q, perf_dlp_q, perf_stall_q;
    logic        xfer_s;

    assign xfer_s = lp_irdy_q && pl_trdy;

    // Performance counters; only beats actually taken by the PHY are counted.
    always_ff @(posedge LCLK) begin
        if (lpreset) begin
            perf_tlp_q   <= 32'd0;
            perf_dlp_q   <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (xfer_s && (lp_tlpend_q != {NB{1'b0}})) begin
                perf_tlp_q <= perf_tlp_q + 32'd1;
            end else begin
                perf_tlp_q <= perf_tlp_q;
            end
            if (xfer_s && (lp_dlpend_q != {NB{1'b0}})) begin
                perf_dlp_q <= perf_dlp_q + 32'd1;
            end else begin
                perf_dlp_q <= perf_dlp_q;
            end
            if (lp_irdy_q && !pl_trdy) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end else begin
                perf_stall_q <= perf_stall_q;
            end
        end
    end

    assign perf_tlp_cnt   = perf_tlp_q;
    assign perf_dlp_cnt   = perf_dlp_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
